// File: rtl/rv_mem_bridge.sv
// Bridges the iosys valid/ready data bus onto a narrower req/ack toggle SDRAM port.
// Each bus access becomes a run of memory beats, with a per-beat ack timeout.
module rv_mem_bridge #(
  parameter int BUS_W   = 32,
  parameter int MEM_W   = 16,
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 1023
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                rv_valid,
  output logic                                rv_ready,
  input  logic [ADDR_W-1:0]                   rv_addr,
  input  logic [BUS_W-1:0]                    rv_wdata,
  input  logic [BUS_W/8-1:0]                  rv_wstrb,
  output logic [BUS_W-1:0]                    rv_rdata,
  output logic                                rv_err,
  output logic                                mem_req,
  input  logic                                mem_ack,
  output logic [ADDR_W-$clog2(MEM_W/8)-1:0]   mem_addr,
  output logic                                mem_we,
  output logic [MEM_W-1:0]                    mem_din,
  output logic [MEM_W/8-1:0]                  mem_ds,
  input  logic [MEM_W-1:0]                    mem_dout
);

  localparam int NB     = BUS_W / MEM_W;
  localparam int SB     = MEM_W / 8;
  localparam int MEM_SH = $clog2(SB);
  localparam int MA_W   = ADDR_W - MEM_SH;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLIM_V = TW'(TLIM);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic              valid_r;
  logic              pending;
  logic              drain;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] addr_r;
  logic [BUS_W-1:0]  wdata_r;
  logic [BUS_W/8-1:0] wstrb_r;
  logic              we_r;
  logic [CW-1:0]     beat;

  logic              new_req;
  logic              ack_match;
  logic              we_in;
  logic              load;
  logic              advance;
  logic              timeout_hit;
  logic              drain_done;
  logic              first_found;
  logic [CW-1:0]     first_beat;
  logic              nxt_found;
  logic [CW-1:0]     nxt_beat;
  logic [MA_W-1:0]   word_base;

  assign new_req   = rv_valid & ~valid_r;
  assign ack_match = (mem_ack == mem_req);
  assign we_in     = |rv_wstrb;
  assign word_base = MA_W'(addr_r >> MEM_SH) & ~MA_W'(NB - 1);

  // First beat of a fresh request: lowest beat with any strobe set on writes, beat 0 on reads.
  always_comb begin
    first_found = 1'b0;
    first_beat  = '0;
    for (int b = 0; b < NB; b++) begin
      if (!first_found && (!we_in || (|rv_wstrb[b*SB +: SB]))) begin
        first_found = 1'b1;
        first_beat  = CW'(b);
      end
    end
  end

  // Next beat after the current one; writes skip beats whose strobe slice is empty.
  always_comb begin
    nxt_found = 1'b0;
    nxt_beat  = '0;
    for (int b = 0; b < NB; b++) begin
      if (!nxt_found && (b > int'(beat)) && (!we_r || (|wstrb_r[b*SB +: SB]))) begin
        nxt_found = 1'b1;
        nxt_beat  = CW'(b);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Acks win over a timeout landing on the same cycle.
  always_comb begin
    state_n     = state;
    load        = 1'b0;
    advance     = 1'b0;
    timeout_hit = 1'b0;
    drain_done  = 1'b0;
    case (state)
      IDLE: begin
        if (new_req || pending) begin
          load    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (ack_match) begin
          if (!we_r) begin
            state_n = CAPTURE;
          end else if (nxt_found) begin
            advance = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = DONE;
          end
        end else if ((TIMEOUT != 0) && (timer == TLIM_V)) begin
          timeout_hit = 1'b1;
          state_n     = DONE;
        end
      end
      CAPTURE: begin
        if (nxt_found) begin
          advance = 1'b1;
          state_n = ISSUE;
        end else begin
          state_n = DONE;
        end
      end
      DONE: state_n = drain ? DRAIN : IDLE;
      DRAIN: begin
        if (ack_match) begin
          drain_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latching, pending edge capture and the drain/timer bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= 1'b0;
      pending <= 1'b0;
      drain   <= 1'b0;
      timer   <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      we_r    <= 1'b0;
      beat    <= '0;
    end else begin
      valid_r <= rv_valid;
      if (new_req && (state != IDLE)) pending <= 1'b1;
      else if (load)                  pending <= 1'b0;
      if (timeout_hit)     drain <= 1'b1;
      else if (drain_done) drain <= 1'b0;
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (load) begin
        addr_r  <= rv_addr;
        wdata_r <= rv_wdata;
        wstrb_r <= rv_wstrb;
        we_r    <= we_in;
        beat    <= first_beat;
      end else if (advance) begin
        beat <= nxt_beat;
      end
    end
  end

  // Memory-side outputs change only in ISSUE and stay put until the next beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      mem_ds   <= '0;
    end else if (state == ISSUE) begin
      mem_req  <= ~mem_req;
      mem_addr <= word_base | MA_W'(beat);
      mem_we   <= we_r;
      mem_din  <= wdata_r[int'(beat)*MEM_W +: MEM_W];
      mem_ds   <= we_r ? wstrb_r[int'(beat)*SB +: SB] : '1;
    end
  end

  // Bus-side response; read slices not captured before a timeout keep their old data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_ready <= 1'b0;
      rv_err   <= 1'b0;
      rv_rdata <= '0;
    end else begin
      rv_ready <= (state_n == DONE);
      rv_err   <= (state_n == DONE) && timeout_hit;
      if (state == CAPTURE) rv_rdata[int'(beat)*MEM_W +: MEM_W] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Directed bench for rv_mem_bridge: a 32/16 instance for most scenarios and a 64/16 one for strobe skipping.
module tb_rv_mem_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic        rv_valid32 = 1'b0;
  logic [22:0] rv_addr32 = '0;
  logic [31:0] rv_wdata32 = '0;
  logic [3:0]  rv_wstrb32 = '0;
  logic        rv_ready32, rv_err32;
  logic [31:0] rv_rdata32;
  logic        mem_req32, mem_we32;
  logic [21:0] mem_addr32;
  logic [15:0] mem_din32;
  logic [1:0]  mem_ds32;
  logic        ack32;
  logic [15:0] dout32;

  logic        rv_valid64 = 1'b0;
  logic [22:0] rv_addr64 = '0;
  logic [63:0] rv_wdata64 = '0;
  logic [7:0]  rv_wstrb64 = '0;
  logic        rv_ready64, rv_err64;
  logic [63:0] rv_rdata64;
  logic        mem_req64, mem_we64;
  logic [21:0] mem_addr64;
  logic [15:0] mem_din64;
  logic [1:0]  mem_ds64;
  logic        ack64;

  rv_mem_bridge #(.BUS_W(32), .MEM_W(16), .ADDR_W(23), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .rv_valid(rv_valid32), .rv_ready(rv_ready32),
    .rv_addr(rv_addr32), .rv_wdata(rv_wdata32), .rv_wstrb(rv_wstrb32),
    .rv_rdata(rv_rdata32), .rv_err(rv_err32), .mem_req(mem_req32), .mem_ack(ack32),
    .mem_addr(mem_addr32), .mem_we(mem_we32), .mem_din(mem_din32), .mem_ds(mem_ds32),
    .mem_dout(dout32)
  );

  rv_mem_bridge #(.BUS_W(64), .MEM_W(16), .ADDR_W(23), .TIMEOUT(8)) dut64 (
    .clk(clk), .resetn(resetn), .rv_valid(rv_valid64), .rv_ready(rv_ready64),
    .rv_addr(rv_addr64), .rv_wdata(rv_wdata64), .rv_wstrb(rv_wstrb64),
    .rv_rdata(rv_rdata64), .rv_err(rv_err64), .mem_req(mem_req64), .mem_ack(ack64),
    .mem_addr(mem_addr64), .mem_we(mem_we64), .mem_din(mem_din64), .mem_ds(mem_ds64),
    .mem_dout(16'h0000)
  );

  // Toggle-port memory model: acks one cycle after a toggle unless held, logs every beat.
  bit          hold32 = 1'b0;
  logic [15:0] mem32 [0:3];
  int          tog32 = 0;
  logic        prev32;
  logic [21:0] log_addr32 [0:15];
  logic [15:0] log_din32 [0:15];
  logic [1:0]  log_ds32 [0:15];
  logic        log_we32 [0:15];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack32  <= 1'b0;
      prev32 <= 1'b0;
      dout32 <= '0;
    end else begin
      prev32 <= mem_req32;
      if (mem_req32 != prev32) begin
        log_addr32[tog32 % 16] <= mem_addr32;
        log_din32[tog32 % 16]  <= mem_din32;
        log_ds32[tog32 % 16]   <= mem_ds32;
        log_we32[tog32 % 16]   <= mem_we32;
        tog32 <= tog32 + 1;
      end
      if ((mem_req32 != ack32) && !hold32) begin
        ack32  <= mem_req32;
        dout32 <= mem32[mem_addr32[1:0]];
      end
    end
  end

  int          tog64 = 0;
  logic        prev64;
  logic [21:0] last_addr64;
  logic [15:0] last_din64;
  logic [1:0]  last_ds64;
  logic        last_we64;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack64  <= 1'b0;
      prev64 <= 1'b0;
    end else begin
      prev64 <= mem_req64;
      if (mem_req64 != prev64) begin
        last_addr64 <= mem_addr64;
        last_din64  <= mem_din64;
        last_ds64   <= mem_ds64;
        last_we64   <= mem_we64;
        tog64 <= tog64 + 1;
      end
      if (mem_req64 != ack64) ack64 <= mem_req64;
    end
  end

  task automatic applyStimulus(input logic [22:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    @(negedge clk);
    rv_addr32  = addr;
    rv_wdata32 = wdata;
    rv_wstrb32 = wstrb;
    rv_valid32 = 1'b1;
  endtask

  // lat counts cycles inclusively from the cycle the request is first sampled; -1 if no rv_ready came.
  task automatic wait_ready32(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (rv_ready32) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rv_ready32, rv_err32, mem_req32, mem_we32} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got %b required 0000", {rv_ready32, rv_err32, mem_req32, mem_we32});
    end
    tests_run++;
    if (rv_rdata32 !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_rdata: got %h required 0", rv_rdata32);
    end
    tests_run++;
    if ({mem_addr32, mem_din32, mem_ds32} !== 40'h0) begin
      tests_failed++; $display("[TB] FAIL reset_mem_outs: got %h required 0", {mem_addr32, mem_din32, mem_ds32});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read;
    int t0, lat;
    t0 = tog32;
    mem32[0] = 16'h1234;
    mem32[1] = 16'hABCD;
    applyStimulus(23'h66000, 32'h0, 4'b0000);
    wait_ready32(40, lat);
    tests_run++;
    if (lat !== 10) begin
      tests_failed++; $display("[TB] FAIL read_latency: got %0d required 10", lat);
    end
    tests_run++;
    if (rv_rdata32 !== 32'hABCD1234 || rv_err32 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL read_data: got %h err %b required abcd1234 err 0", rv_rdata32, rv_err32);
    end
    rv_valid32 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rv_ready32 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ready_pulse: got %b required 0", rv_ready32);
    end
    tests_run++;
    if (tog32 - t0 !== 2) begin
      tests_failed++; $display("[TB] FAIL read_toggles: got %0d required 2", tog32 - t0);
    end
    tests_run++;
    if (log_addr32[t0 % 16] !== 22'h33000 || log_addr32[(t0 + 1) % 16] !== 22'h33001) begin
      tests_failed++; $display("[TB] FAIL read_addr: got %h,%h required 33000,33001", log_addr32[t0 % 16], log_addr32[(t0 + 1) % 16]);
    end
    tests_run++;
    if (log_ds32[t0 % 16] !== 2'b11 || log_we32[t0 % 16] !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL read_ds_we: got ds %b we %b required 11 0", log_ds32[t0 % 16], log_we32[t0 % 16]);
    end
  endtask

  task automatic test_write;
    int t0, lat;
    t0 = tog32;
    applyStimulus(23'h66000, 32'hDEAD0000, 4'b1100);
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat !== 5 || rv_err32 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL write_latency: got %0d err %b required 5 err 0", lat, rv_err32);
    end
    tests_run++;
    if (tog32 - t0 !== 1) begin
      tests_failed++; $display("[TB] FAIL write_toggles: got %0d required 1", tog32 - t0);
    end
    tests_run++;
    if ({log_addr32[t0 % 16], log_din32[t0 % 16], log_ds32[t0 % 16], log_we32[t0 % 16]} !== {22'h33001, 16'hDEAD, 2'b11, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL write_beat: got addr %h din %h ds %b we %b required 33001 dead 11 1",
        log_addr32[t0 % 16], log_din32[t0 % 16], log_ds32[t0 % 16], log_we32[t0 % 16]);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_strobe;
    int t0, lat;
    t0 = tog32;
    mem32[2] = 16'h5555;
    mem32[3] = 16'h7777;
    applyStimulus(23'h66004, 32'hFFFFFFFF, 4'b0000);
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat !== 10 || rv_rdata32 !== 32'h77775555) begin
      tests_failed++; $display("[TB] FAIL zero_strobe_read: got lat %0d data %h required 10 77775555", lat, rv_rdata32);
    end
    tests_run++;
    if (tog32 - t0 !== 2 || log_we32[t0 % 16] !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL zero_strobe_beats: got %0d we %b required 2 0", tog32 - t0, log_we32[t0 % 16]);
    end
    @(negedge clk);
  endtask

  task automatic test_wide_write;
    int t0, lat;
    t0 = tog64;
    lat = -1;
    @(negedge clk);
    rv_addr64  = 23'h000100;
    rv_wdata64 = 64'h1111_2222_3333_4444;
    rv_wstrb64 = 8'b0011_0000;
    rv_valid64 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rv_ready64) begin
        lat = i + 1;
        break;
      end
    end
    rv_valid64 = 1'b0;
    tests_run++;
    if (lat !== 5 || rv_err64 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL wide_latency: got %0d err %b required 5 err 0", lat, rv_err64);
    end
    tests_run++;
    if (tog64 - t0 !== 1) begin
      tests_failed++; $display("[TB] FAIL wide_toggles: got %0d required 1", tog64 - t0);
    end
    tests_run++;
    if ({last_addr64, last_din64, last_ds64, last_we64} !== {22'h000082, 16'h2222, 2'b11, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL wide_beat: got addr %h din %h ds %b we %b required 82 2222 11 1",
        last_addr64, last_din64, last_ds64, last_we64);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int t0, lat;
    bit early_ready;
    t0 = tog32;
    hold32 = 1'b1;
    applyStimulus(23'h66008, 32'h0, 4'b0000);
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat !== 11 || rv_err32 !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL timeout_resp: got lat %0d err %b required 11 err 1", lat, rv_err32);
    end
    tests_run++;
    if (rv_rdata32 !== 32'h77775555) begin
      tests_failed++; $display("[TB] FAIL timeout_rdata_kept: got %h required 77775555", rv_rdata32);
    end
    applyStimulus(23'h66000, 32'h0, 4'b0000);
    early_ready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rv_ready32) early_ready = 1'b1;
    end
    tests_run++;
    if (tog32 - t0 !== 1 || early_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL drain_hold: got toggles %0d ready %b required 1 0", tog32 - t0, early_ready);
    end
    hold32 = 1'b0;
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat === -1 || rv_err32 !== 1'b0 || rv_rdata32 !== 32'hABCD1234) begin
      tests_failed++; $display("[TB] FAIL after_drain: got lat %0d err %b data %h required ready err 0 abcd1234", lat, rv_err32, rv_rdata32);
    end
    tests_run++;
    if (tog32 - t0 !== 3) begin
      tests_failed++; $display("[TB] FAIL after_drain_toggles: got %0d required 3", tog32 - t0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t0, lat;
    t0 = tog32;
    applyStimulus(23'h66000, 32'h0, 4'b0000);
    repeat (3) @(negedge clk);
    rv_valid32 = 1'b0;
    rv_addr32  = 23'h66004;
    @(negedge clk);
    rv_valid32 = 1'b1;
    wait_ready32(40, lat);
    tests_run++;
    if (lat === -1 || rv_rdata32 !== 32'hABCD1234) begin
      tests_failed++; $display("[TB] FAIL b2b_first: got lat %0d data %h required ready abcd1234", lat, rv_rdata32);
    end
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat === -1 || rv_rdata32 !== 32'h77775555 || rv_err32 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got lat %0d data %h err %b required ready 77775555 0", lat, rv_rdata32, rv_err32);
    end
    tests_run++;
    if (tog32 - t0 !== 4 || log_addr32[(t0 + 2) % 16] !== 22'h33002) begin
      tests_failed++; $display("[TB] FAIL b2b_beats: got %0d toggles third addr %h required 4 33002", tog32 - t0, log_addr32[(t0 + 2) % 16]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    hold32 = 1'b1;
    applyStimulus(23'h66000, 32'h0, 4'b0000);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({rv_ready32, rv_err32, mem_req32, mem_we32} !== 4'b0000 || rv_rdata32 !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL async_reset_flags: got %b data %h required 0000 0", {rv_ready32, rv_err32, mem_req32, mem_we32}, rv_rdata32);
    end
    tests_run++;
    if ({mem_addr32, mem_din32, mem_ds32} !== 40'h0) begin
      tests_failed++; $display("[TB] FAIL async_reset_mem: got %h required 0", {mem_addr32, mem_din32, mem_ds32});
    end
    rv_valid32 = 1'b0;
    hold32 = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(23'h66000, 32'h0, 4'b0000);
    wait_ready32(40, lat);
    rv_valid32 = 1'b0;
    tests_run++;
    if (lat !== 10 || rv_rdata32 !== 32'hABCD1234 || rv_err32 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL post_reset_read: got lat %0d data %h err %b required 10 abcd1234 0", lat, rv_rdata32, rv_err32);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_zero_strobe;
    test_wide_write;
    test_timeout;
    test_back_to_back;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
